// File: rtl/wb_regfile_pkg.sv
// Shared constants and encodings for the writeback stage and register file.
package rv_pkg;

   localparam int XLEN    = 32;
   localparam int NREG    = 32;
   localparam int CNT_W   = 64;
   localparam int RADDR_W = $clog2(NREG);

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_MEM  = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle: pipeline register outputs in, read ports and forwarding out.
interface wb_regfile_if;
   import rv_pkg::*;

   logic                 wb_valid;
   logic [XLEN-1:0]      PC_plus_4_mo;
   logic [XLEN-1:0]      Read_data_dm_mo;
   logic [XLEN-1:0]      ALU_result_mo;
   logic [RADDR_W-1:0]   Rd_mo;
   logic [1:0]           Wr_data_sel_mo;
   logic                 Reg_wr_mo;
   logic [2:0]           load_fmt;
   logic [RADDR_W-1:0]   rs1_addr;
   logic [RADDR_W-1:0]   rs2_addr;
   logic [XLEN-1:0]      rs1_data;
   logic [XLEN-1:0]      rs2_data;
   logic [XLEN-1:0]      wb_data;
   logic                 wb_we;
   logic [CNT_W-1:0]     instret;

   modport master (
      output wb_valid, PC_plus_4_mo, Read_data_dm_mo, ALU_result_mo, Rd_mo,
             Wr_data_sel_mo, Reg_wr_mo, load_fmt, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_data, wb_we, instret
   );

   modport slave (
      input  wb_valid, PC_plus_4_mo, Read_data_dm_mo, ALU_result_mo, Rd_mo,
             Wr_data_sel_mo, Reg_wr_mo, load_fmt, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_data, wb_we, instret
   );

endinterface

// File: rtl/wb_regfile_load_align.sv
// Load data formatter: picks the addressed byte/halfword lane and extends it per funct3.
module load_align
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_i[7:0];
      case (offset_i)
         2'd0: byte_lane = word_i[7:0];
         2'd1: byte_lane = word_i[15:8];
         2'd2: byte_lane = word_i[23:16];
         2'd3: byte_lane = word_i[31:24];
         default: byte_lane = word_i[7:0];
      endcase
      // Halfword lane ignores offset bit 0; misaligned halfwords are not trapped here.
      half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LH:   data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
         F3_LW:   data_o = word_i;
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_lane};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the 32x32 register file
// with write-first read bypass, and counts retired instructions.
module wb_regfile
   import rv_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   wb_regfile_if.slave  bus
);

   logic [XLEN-1:0]  regs_q [NREG];
   logic [XLEN-1:0]  regs_d [NREG];
   logic [CNT_W-1:0] instret_q;
   logic [CNT_W-1:0] instret_d;
   logic [XLEN-1:0]  load_data;
   logic [XLEN-1:0]  wb_data;
   logic             wb_we;

   load_align u_load_align (
      .word_i   (bus.Read_data_dm_mo),
      .offset_i (bus.ALU_result_mo[1:0]),
      .funct3_i (bus.load_fmt),
      .data_o   (load_data)
   );

   always_comb begin
      wb_data = '0;
      case (wb_sel_e'(bus.Wr_data_sel_mo))
         WB_SEL_ALU:  wb_data = bus.ALU_result_mo;
         WB_SEL_MEM:  wb_data = load_data;
         WB_SEL_PC4:  wb_data = bus.PC_plus_4_mo;
         default:     wb_data = '0;
      endcase
      wb_we = bus.wb_valid & bus.Reg_wr_mo & (bus.Rd_mo != '0) &
              (wb_sel_e'(bus.Wr_data_sel_mo) != WB_SEL_RSVD);
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_we) regs_d[bus.Rd_mo] = wb_data;
      instret_d = instret_q + CNT_W'(bus.wb_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q    <= '{default: '0};
         instret_q <= '0;
      end else begin
         regs_q    <= regs_d;
         instret_q <= instret_d;
      end
   end

   // x0 check comes first so a (suppressed) write to x0 can never leak through the bypass.
   always_comb begin
      if (bus.rs1_addr == '0)                    bus.rs1_data = '0;
      else if (wb_we && bus.rs1_addr == bus.Rd_mo) bus.rs1_data = wb_data;
      else                                       bus.rs1_data = regs_q[bus.rs1_addr];

      if (bus.rs2_addr == '0)                    bus.rs2_data = '0;
      else if (wb_we && bus.rs2_addr == bus.Rd_mo) bus.rs2_data = wb_data;
      else                                       bus.rs2_data = regs_q[bus.rs2_addr];
   end

   assign bus.wb_data = wb_data;
   assign bus.wb_we   = wb_we;
   assign bus.instret = instret_q;

endmodule
